// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: CPU address decoder for RAM, PPU registers, controller port, PRG ROM and OAM DMA.
// Ports: clk/rst (sync, active-high); cpu_* bus in, cpu_rdata registered out, cpu_halt high during DMA;
// ppu_reg_* PPU register window; prg_addr/prg_rdata combinational PRG ROM; ctrl_buttons controller 1.
module cpu_bus_responder #(
  parameter bit PRG_MIRROR_16K = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_write_en,
  input  logic        cpu_read_en,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_halt,
  output logic [2:0]  ppu_reg_addr,
  output logic [7:0]  ppu_reg_wdata,
  output logic        ppu_reg_we,
  output logic        ppu_reg_re,
  input  logic [7:0]  ppu_reg_rdata,
  output logic [14:0] prg_addr,
  input  logic [7:0]  prg_rdata,
  input  logic [7:0]  ctrl_buttons
);
  typedef enum logic [1:0] {IDLE, ALIGN, RD, WR} state_t;
  state_t state_q, state_d;
  logic [7:0] rdata_q, rdata_d, idx_q, idx_d, page_q, page_d, byte_q, byte_d, shift_q, shift_d, dma_src;
  logic strobe_q, strobe_d;
  logic [7:0] ram_q [2048];
  logic [15:0] dma_addr;
  logic cpu_wr, cpu_rd, sel_ram, sel_ppu, sel_ctl, sel_prg, sel_dma;
  assign cpu_halt = state_q != IDLE;
  // a simultaneous read+write is treated as a write only
  assign cpu_wr = cpu_write_en && !cpu_halt;
  assign cpu_rd = cpu_read_en && !cpu_write_en && !cpu_halt;
  assign sel_ram = cpu_addr[15:13] == 3'b000;
  assign sel_ppu = cpu_addr[15:13] == 3'b001;
  assign sel_dma = cpu_addr == 16'h4014;
  assign sel_ctl = cpu_addr == 16'h4016;
  assign sel_prg = cpu_addr[15];
  assign dma_addr = {page_q, idx_q};
  // the PRG port is borrowed by DMA only during its READ cycle
  assign prg_addr = (state_q == RD ? dma_addr[14:0] : cpu_addr[14:0]) & {~PRG_MIRROR_16K, 14'h3FFF};
  assign dma_src = dma_addr[15:13] == 3'b000 ? ram_q[dma_addr[10:0]] : dma_addr[15] ? prg_rdata : 8'h00;
  assign cpu_rdata = rdata_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    page_d = page_q;
    byte_d = byte_q;
    case (state_q)
      IDLE: if (cpu_wr && sel_dma) begin
        state_d = ALIGN;
        page_d = cpu_wdata;
        idx_d = 8'h00;
      end
      ALIGN: state_d = RD;
      RD: begin
        state_d = WR;
        byte_d = dma_src;
      end
      default: begin
        state_d = idx_q == 8'hFF ? IDLE : RD;
        idx_d = idx_q + 8'h01;
      end
    endcase
    ppu_reg_addr = state_q == WR ? 3'd4 : cpu_addr[2:0];
    ppu_reg_wdata = state_q == WR ? byte_q : cpu_wdata;
    ppu_reg_we = state_q == WR || (cpu_wr && sel_ppu);
    ppu_reg_re = cpu_rd && sel_ppu;
    rdata_d = !cpu_rd ? rdata_q :
              sel_ram ? ram_q[cpu_addr[10:0]] :
              sel_ppu ? ppu_reg_rdata :
              sel_ctl ? {7'b0, shift_q[0]} :
              sel_prg ? prg_rdata : rdata_q;
    strobe_d = cpu_wr && sel_ctl ? cpu_wdata[0] : strobe_q;
    shift_d = strobe_q ? ctrl_buttons : cpu_rd && sel_ctl ? {1'b1, shift_q[7:1]} : shift_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= 8'h00;
      page_q <= 8'h00;
      byte_q <= 8'h00;
      rdata_q <= 8'h00;
      strobe_q <= 1'b0;
      shift_q <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      page_q <= page_d;
      byte_q <= byte_d;
      rdata_q <= rdata_d;
      strobe_q <= strobe_d;
      shift_q <= shift_d;
    end
  end
  always_ff @(posedge clk) begin
    if (cpu_wr && sel_ram) ram_q[cpu_addr[10:0]] <= cpu_wdata;
  end
endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb_cpu_bus_responder: scoreboard bench for cpu_bus_responder with the 16K PRG mirror enabled.
module tb_cpu_bus_responder;
  logic clk = 1'b0, rst;
  logic [15:0] cpu_addr;
  logic [7:0] cpu_wdata, cpu_rdata, ppu_reg_wdata, ppu_reg_rdata, prg_rdata, ctrl_buttons;
  logic cpu_write_en, cpu_read_en, cpu_halt, ppu_reg_we, ppu_reg_re;
  logic [2:0] ppu_reg_addr;
  logic [14:0] prg_addr;
  int checks = 0, failures = 0;
  logic [7:0] exp_q [$];
  logic [7:0] got, mem [16];
  always #5 clk = ~clk;
  assign prg_rdata = prg_addr[7:0] ^ 8'h3C;
  cpu_bus_responder #(.PRG_MIRROR_16K(1'b1)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_write_en(cpu_write_en), .cpu_read_en(cpu_read_en), .cpu_rdata(cpu_rdata),
    .cpu_halt(cpu_halt), .ppu_reg_addr(ppu_reg_addr), .ppu_reg_wdata(ppu_reg_wdata),
    .ppu_reg_we(ppu_reg_we), .ppu_reg_re(ppu_reg_re), .ppu_reg_rdata(ppu_reg_rdata),
    .prg_addr(prg_addr), .prg_rdata(prg_rdata), .ctrl_buttons(ctrl_buttons)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a;
    cpu_wdata = d;
    cpu_write_en = 1'b1;
    cpu_read_en = 1'b0;
    tick;
    cpu_write_en = 1'b0;
  endtask
  task automatic rd(input logic [15:0] a, input logic [7:0] e);
    cpu_addr = a;
    cpu_read_en = 1'b1;
    cpu_write_en = 1'b0;
    exp_q.push_back(e);
    tick;
    cpu_read_en = 1'b0;
  endtask
  task automatic test_reset;
    cpu_addr = 16'h0000;
    cpu_wdata = 8'h00;
    cpu_write_en = 1'b0;
    cpu_read_en = 1'b0;
    ppu_reg_rdata = 8'h00;
    ctrl_buttons = 8'h00;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    checks += 4;
    if (cpu_rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", cpu_rdata); end
    if (cpu_halt !== 1'b0) begin failures++; $display("FAIL reset_halt got=%b exp=0", cpu_halt); end
    if (ppu_reg_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", ppu_reg_we); end
    if (ppu_reg_re !== 1'b0) begin failures++; $display("FAIL reset_re got=%b exp=0", ppu_reg_re); end
  endtask
  task automatic test_ram;
    wr(16'h0005, 8'hA5);
    rd(16'h0805, 8'hA5);
    got = exp_q.pop_front();
    checks++;
    if (cpu_rdata !== got) begin failures++; $display("FAIL ram_mirror got=%h exp=%h", cpu_rdata, got); end
    for (int i = 0; i < 16; i++) begin
      mem[i] = 8'($urandom);
      wr(16'h0100 + 16'(i), mem[i]);
    end
    for (int i = 0; i < 16; i++) begin
      rd(16'h0100 + 16'(i) + 16'h0800 * 16'(i % 4), mem[i]);
      got = exp_q.pop_front();
      checks++;
      if (cpu_rdata !== got) begin failures++; $display("FAIL ram_rd%0d got=%h exp=%h", i, cpu_rdata, got); end
    end
    rd(16'h5000, mem[15]);
    got = exp_q.pop_front();
    checks++;
    if (cpu_rdata !== got) begin failures++; $display("FAIL open_bus got=%h exp=%h", cpu_rdata, got); end
    rd(16'h4014, mem[15]);
    got = exp_q.pop_front();
    checks++;
    if (cpu_rdata !== got) begin failures++; $display("FAIL open_4014 got=%h exp=%h", cpu_rdata, got); end
    cpu_addr = 16'h0010;
    cpu_wdata = 8'h77;
    cpu_write_en = 1'b1;
    cpu_read_en = 1'b1;
    exp_q.push_back(mem[15]);
    tick;
    cpu_write_en = 1'b0;
    cpu_read_en = 1'b0;
    got = exp_q.pop_front();
    checks++;
    if (cpu_rdata !== got) begin failures++; $display("FAIL rw_both got=%h exp=%h", cpu_rdata, got); end
    rd(16'h0010, 8'h77);
    got = exp_q.pop_front();
    checks++;
    if (cpu_rdata !== got) begin failures++; $display("FAIL rw_write got=%h exp=%h", cpu_rdata, got); end
  endtask
  task automatic test_ppu;
    cpu_addr = 16'h3FFA;
    ppu_reg_rdata = 8'h80;
    cpu_read_en = 1'b1;
    exp_q.push_back(8'h80);
    #1;
    checks += 3;
    if (ppu_reg_re !== 1'b1) begin failures++; $display("FAIL ppu_re got=%b exp=1", ppu_reg_re); end
    if (ppu_reg_addr !== 3'd2) begin failures++; $display("FAIL ppu_raddr got=%0d exp=2", ppu_reg_addr); end
    if (ppu_reg_we !== 1'b0) begin failures++; $display("FAIL ppu_rd_we got=%b exp=0", ppu_reg_we); end
    tick;
    cpu_read_en = 1'b0;
    ppu_reg_rdata = 8'h00;
    #1;
    got = exp_q.pop_front();
    checks += 2;
    if (cpu_rdata !== got) begin failures++; $display("FAIL ppu_rdata got=%h exp=%h", cpu_rdata, got); end
    if (ppu_reg_re !== 1'b0) begin failures++; $display("FAIL ppu_re_drop got=%b exp=0", ppu_reg_re); end
    cpu_addr = 16'h2006;
    cpu_wdata = 8'h3F;
    cpu_write_en = 1'b1;
    #1;
    checks += 3;
    if (ppu_reg_we !== 1'b1 || ppu_reg_re !== 1'b0) begin failures++; $display("FAIL ppu_we got=%b%b exp=10", ppu_reg_we, ppu_reg_re); end
    if (ppu_reg_addr !== 3'd6) begin failures++; $display("FAIL ppu_waddr got=%0d exp=6", ppu_reg_addr); end
    if (ppu_reg_wdata !== 8'h3F) begin failures++; $display("FAIL ppu_wdata got=%h exp=3F", ppu_reg_wdata); end
    tick;
    cpu_write_en = 1'b0;
  endtask
  task automatic test_ctrl;
    logic [8:0] pat;
    pat = 9'b110000001;
    ctrl_buttons = 8'h81;
    wr(16'h4016, 8'h01);
    wr(16'h4016, 8'h00);
    ctrl_buttons = 8'h00;
    for (int i = 0; i < 9; i++) begin
      rd(16'h4016, {7'b0, pat[i]});
      got = exp_q.pop_front();
      checks++;
      if (cpu_rdata !== got) begin failures++; $display("FAIL ctrl_rd%0d got=%h exp=%h", i, cpu_rdata, got); end
    end
    wr(16'h4016, 8'h01);
    ctrl_buttons = 8'h03;
    tick;
    for (int i = 0; i < 2; i++) begin
      rd(16'h4016, 8'h01);
      got = exp_q.pop_front();
      checks++;
      if (cpu_rdata !== got) begin failures++; $display("FAIL ctrl_strobe%0d got=%h exp=%h", i, cpu_rdata, got); end
    end
    ctrl_buttons = 8'h02;
    tick;
    rd(16'h4016, 8'h00);
    got = exp_q.pop_front();
    checks++;
    if (cpu_rdata !== got) begin failures++; $display("FAIL ctrl_reload got=%h exp=%h", cpu_rdata, got); end
    wr(16'h4016, 8'h00);
  endtask
  task automatic test_prg;
    cpu_addr = 16'hC123;
    cpu_read_en = 1'b1;
    exp_q.push_back(8'h23 ^ 8'h3C);
    #1;
    checks++;
    if (prg_addr !== 15'h0123) begin failures++; $display("FAIL prg_mirror got=%h exp=0123", prg_addr); end
    tick;
    cpu_read_en = 1'b0;
    got = exp_q.pop_front();
    checks++;
    if (cpu_rdata !== got) begin failures++; $display("FAIL prg_rdata got=%h exp=%h", cpu_rdata, got); end
    wr(16'h8000, 8'hFF);
    checks += 2;
    if (cpu_rdata !== got) begin failures++; $display("FAIL prg_write got=%h exp=%h", cpu_rdata, got); end
    if (cpu_halt !== 1'b0) begin failures++; $display("FAIL prg_write_halt got=%b exp=0", cpu_halt); end
    rd(16'h0000, 8'h00);
    exp_q.pop_front();
    rd(16'h0000, 8'h00);
    got = exp_q.pop_front();
    checks++;
    if (cpu_rdata !== 8'h00 && cpu_rdata !== 8'hFF) begin failures++; $display("FAIL prg_ram_alias got=%h exp=not FF", cpu_rdata); end
  endtask
  task automatic test_dma;
    int halt_cnt, pulses;
    logic [7:0] held;
    for (int i = 0; i < 256; i++) begin
      wr({8'h02, 8'(i)}, 8'(i) ^ 8'h5A);
      exp_q.push_back(8'(i) ^ 8'h5A);
    end
    held = cpu_rdata;
    halt_cnt = 0;
    pulses = 0;
    wr(16'h4014, 8'h02);
    for (int c = 0; c < 600 && cpu_halt; c++) begin
      halt_cnt++;
      if (ppu_reg_we) begin
        pulses++;
        got = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (ppu_reg_addr !== 3'd4 || ppu_reg_wdata !== got) begin
          failures++;
          $display("FAIL dma_pulse%0d got=%0d/%h exp=4/%h", pulses, ppu_reg_addr, ppu_reg_wdata, got);
        end
      end
      if (c < 4 && ppu_reg_re !== 1'b0) begin checks++; failures++; $display("FAIL dma_re got=%b exp=0", ppu_reg_re); end
      cpu_addr = c < 4 ? 16'h2002 : 16'h4014;
      cpu_wdata = 8'h07;
      cpu_read_en = c < 4;
      cpu_write_en = c >= 4 && c < 8;
      #1;
      if (c < 4) begin
        checks++;
        if (ppu_reg_re !== 1'b0) begin failures++; $display("FAIL dma_re_hold got=%b exp=0", ppu_reg_re); end
      end
      tick;
      cpu_read_en = 1'b0;
      cpu_write_en = 1'b0;
    end
    checks += 5;
    if (halt_cnt !== 513) begin failures++; $display("FAIL dma_halt_cycles got=%0d exp=513", halt_cnt); end
    if (pulses !== 256) begin failures++; $display("FAIL dma_pulses got=%0d exp=256", pulses); end
    if (exp_q.size() !== 0) begin failures++; $display("FAIL dma_queue got=%0d exp=0", exp_q.size()); end
    if (cpu_rdata !== held) begin failures++; $display("FAIL dma_rdata_held got=%h exp=%h", cpu_rdata, held); end
    tick;
    if (cpu_halt !== 1'b0 || ppu_reg_we !== 1'b0) begin failures++; $display("FAIL dma_done got=%b%b exp=00", cpu_halt, ppu_reg_we); end
  endtask
  task automatic test_dma_reset;
    int pulses;
    rd(16'h0005, 8'hA5);
    got = exp_q.pop_front();
    checks++;
    if (cpu_rdata !== got) begin failures++; $display("FAIL pre_rst_rd got=%h exp=%h", cpu_rdata, got); end
    wr(16'h4014, 8'h02);
    repeat (99) tick;
    checks++;
    if (cpu_halt !== 1'b1) begin failures++; $display("FAIL mid_dma_halt got=%b exp=1", cpu_halt); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks += 3;
    if (cpu_halt !== 1'b0) begin failures++; $display("FAIL rst_abort_halt got=%b exp=0", cpu_halt); end
    if (ppu_reg_we !== 1'b0) begin failures++; $display("FAIL rst_abort_we got=%b exp=0", ppu_reg_we); end
    if (cpu_rdata !== 8'h00) begin failures++; $display("FAIL rst_abort_rdata got=%h exp=00", cpu_rdata); end
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      pulses += int'(ppu_reg_we) + int'(cpu_halt);
      tick;
    end
    checks++;
    if (pulses !== 0) begin failures++; $display("FAIL rst_abort_quiet got=%0d exp=0", pulses); end
    rd(16'h0005, 8'hA5);
    got = exp_q.pop_front();
    checks++;
    if (cpu_rdata !== got) begin failures++; $display("FAIL ram_kept got=%h exp=%h", cpu_rdata, got); end
  endtask
  initial begin
    test_reset;
    test_ram;
    test_ppu;
    test_ctrl;
    test_prg;
    test_dma;
    test_dma_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
